// File: rtl/clock_bus_display_scan_if.sv
// Time bus from the timekeeping core plus the display and status pins of the scan block.
// The master drives the time bytes and the slave (the scan block) drives the display.
interface clock_bus_display_scan_if;
    logic [7:0] time_lo;
    logic [7:0] time_hi;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig_en;
    logic       frame_err;
    logic       busy;

    modport master (
        output time_lo, time_hi,
        input  seg, dp, dig_en, frame_err, busy
    );

    modport slave (
        input  time_lo, time_hi,
        output seg, dp, dig_en, frame_err, busy
    );
endinterface

// File: rtl/clock_bus_display_scan.sv
// Receives the packed 12-hour time bus, validates each new frame, converts hours and
// minutes to BCD with a shared serial double-dabble engine and scans a 4-digit display.
module clock_bus_display_scan #(
    parameter int SCAN_DIV      = 1024,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ena,
    clock_bus_display_scan_if.slave        bus
);

    localparam int              PW        = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]   PRE_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [3:0]      DIG_DASH  = 4'hA;
    localparam logic [3:0]      DIG_BLANK = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV_H = 2'd1,
        ST_CONV_M = 2'd2,
        ST_LOAD   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      cap_q, cap_d;
    logic             cap_vld_q, cap_vld_d;
    logic [15:0]      src_q, src_d;
    logic             disp_valid_q, disp_valid_d;
    logic             busy_q, busy_d;
    logic             frame_err_q, frame_err_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [5:0]       bin_q, bin_d;
    logic [7:0]       bcd_q, bcd_d;
    logic [7:0]       hbcd_q, hbcd_d;
    logic [3:0][3:0]  dig_q, dig_d;
    logic             pm_q, pm_d;
    logic             sec_q, sec_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [1:0]       idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       dig_en_q, dig_en_d;
    logic [13:0]      step_s;

    function automatic logic frame_ok(input logic [15:0] f);
        return (f[3:0] >= 4'd1) && (f[3:0] <= 4'd12) && (f[13:8] <= 6'd59)
            && (f[6] == 1'b0) && (f[15:14] == 2'b00);
    endfunction

    // One double-dabble iteration: add 3 to nibbles >= 5, then shift {bcd, bin} left by one.
    function automatic logic [13:0] dd_step(input logic [7:0] bcd, input logic [5:0] bin);
        logic [7:0] adj;
        adj[3:0] = (bcd[3:0] >= 4'd5) ? (bcd[3:0] + 4'd3) : bcd[3:0];
        adj[7:4] = (bcd[7:4] >= 4'd5) ? (bcd[7:4] + 4'd3) : bcd[7:4];
        return {adj[6:0], bin, 1'b0};
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            4'hA:    s = 7'h40;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign step_s = dd_step(bcd_q, bin_q);

    // Next-state logic: capture, conversion FSM, display registers, scan and output stage.
    always_comb begin
        state_d      = state_q;
        cap_d        = cap_q;
        cap_vld_d    = cap_vld_q;
        src_d        = src_q;
        disp_valid_d = disp_valid_q;
        busy_d       = busy_q;
        frame_err_d  = frame_err_q;
        cnt_d        = cnt_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        hbcd_d       = hbcd_q;
        dig_d        = dig_q;
        pm_d         = pm_q;
        sec_d        = sec_q;
        pre_d        = pre_q;
        idx_d        = idx_q;
        seg_d        = seg_q;
        dp_d         = dp_q;
        dig_en_d     = dig_en_q;

        if (ena) begin
            cap_d     = {bus.time_hi, bus.time_lo};
            cap_vld_d = 1'b1;

            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                idx_d = idx_q + 2'd1;
            end else begin
                pre_d = pre_q + {{(PW-1){1'b0}}, 1'b1};
            end

            case (state_q)
                ST_IDLE: begin
                    // cap_vld guards against evaluating the reset value of cap as a frame.
                    if (cap_vld_q && (!disp_valid_q || (cap_q != src_q))) begin
                        src_d = cap_q;
                        if (frame_ok(cap_q)) begin
                            state_d = ST_CONV_H;
                            busy_d  = 1'b1;
                            bcd_d   = 8'd0;
                            bin_d   = {cap_q[3:0], 2'b00};
                            cnt_d   = 3'd0;
                        end else begin
                            frame_err_d  = 1'b1;
                            dig_d        = {4{DIG_DASH}};
                            pm_d         = 1'b0;
                            sec_d        = 1'b0;
                            disp_valid_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CONV_H: begin
                    {bcd_d, bin_d} = step_s;
                    cnt_d          = cnt_q + 3'd1;
                    if (cnt_q == 3'd3) begin
                        hbcd_d  = step_s[13:6];
                        bcd_d   = 8'd0;
                        bin_d   = src_q[13:8];
                        cnt_d   = 3'd0;
                        state_d = ST_CONV_M;
                    end else begin
                        state_d = ST_CONV_H;
                    end
                end
                ST_CONV_M: begin
                    {bcd_d, bin_d} = step_s;
                    cnt_d          = cnt_q + 3'd1;
                    if (cnt_q == 3'd5) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_CONV_M;
                    end
                end
                ST_LOAD: begin
                    dig_d[0]     = bcd_q[3:0];
                    dig_d[1]     = bcd_q[7:4];
                    dig_d[2]     = hbcd_q[3:0];
                    dig_d[3]     = (BLANK_LEADING && (hbcd_q[7:4] == 4'd0)) ? DIG_BLANK : hbcd_q[7:4];
                    pm_d         = src_q[7];
                    sec_d        = src_q[4];
                    frame_err_d  = 1'b0;
                    disp_valid_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase

            seg_d    = seg_code(dig_q[idx_q]);
            dig_en_d = 4'b0001 << idx_q;
            case (idx_q)
                2'd0:    dp_d = pm_q;
                2'd2:    dp_d = sec_q;
                default: dp_d = 1'b0;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State registers; reset aborts any conversion in flight and blanks the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cap_q        <= 16'd0;
            cap_vld_q    <= 1'b0;
            src_q        <= 16'd0;
            disp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            cnt_q        <= 3'd0;
            bin_q        <= 6'd0;
            bcd_q        <= 8'd0;
            hbcd_q       <= 8'd0;
            dig_q        <= {4{DIG_BLANK}};
            pm_q         <= 1'b0;
            sec_q        <= 1'b0;
            pre_q        <= '0;
            idx_q        <= 2'd0;
            seg_q        <= 7'd0;
            dp_q         <= 1'b0;
            dig_en_q     <= 4'b0001;
        end else begin
            state_q      <= state_d;
            cap_q        <= cap_d;
            cap_vld_q    <= cap_vld_d;
            src_q        <= src_d;
            disp_valid_q <= disp_valid_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
            cnt_q        <= cnt_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            hbcd_q       <= hbcd_d;
            dig_q        <= dig_d;
            pm_q         <= pm_d;
            sec_q        <= sec_d;
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            dig_en_q     <= dig_en_d;
        end
    end

    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
    assign bus.dig_en    = dig_en_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_clock_bus_display_scan.sv
// Directed bench for clock_bus_display_scan with a short scan divider.
module tb_clock_bus_display_scan;

    logic clk;
    logic rst_n;
    logic ena;
    int   n_checks;
    int   n_errors;

    clock_bus_display_scan_if bif();

    clock_bus_display_scan #(
        .SCAN_DIV      (4),
        .BLANK_LEADING (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply(input logic [7:0] lo, input logic [7:0] hi);
        bif.time_lo = lo;
        bif.time_hi = hi;
    endtask

    task automatic wait_busy_rise(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bif.busy === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq({tag, "_busy_rise"}, 32'(found), 32'd1);
    endtask

    task automatic count_level(input logic lvl, output int n);
        n = 0;
        while ((bif.busy === lvl) && (n < 40)) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Waits for a conversion and checks its length; reports frame_err at start/end and nonzero seg samples.
    task automatic run_conv(input string tag, output logic fe_start, output logic fe_end, output int nz);
        int n;
        nz = 0;
        wait_busy_rise(tag);
        fe_start = bif.frame_err;
        n = 0;
        while ((bif.busy === 1'b1) && (n < 40)) begin
            if (bif.seg !== 7'h00) nz++;
            n++;
            @(negedge clk);
        end
        fe_end = bif.frame_err;
        check_eq({tag, "_busy_len"}, 32'(n), 32'd11);
    endtask

    task automatic scan_check(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0, input logic [3:0] edp);
        logic [6:0] so [4];
        logic [3:0] dpo;
        logic [3:0] seen;
        int         bad;
        int         k;
        seen = 4'd0;
        dpo  = 4'd0;
        bad  = 0;
        for (int i = 0; i < 4; i++) so[i] = 7'd0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            k = -1;
            case (bif.dig_en)
                4'b0001: k = 0;
                4'b0010: k = 1;
                4'b0100: k = 2;
                4'b1000: k = 3;
                default: bad++;
            endcase
            if (k >= 0) begin
                if (seen[k] && ((so[k] !== bif.seg) || (dpo[k] !== bif.dp))) bad++;
                so[k]   = bif.seg;
                dpo[k]  = bif.dp;
                seen[k] = 1'b1;
            end
        end
        check_eq({tag, "_seen"}, 32'(seen), 32'hF);
        check_eq({tag, "_bad"},  32'(bad), 32'd0);
        check_eq({tag, "_d3"},   32'(so[3]), 32'(e3));
        check_eq({tag, "_d2"},   32'(so[2]), 32'(e2));
        check_eq({tag, "_d1"},   32'(so[1]), 32'(e1));
        check_eq({tag, "_d0"},   32'(so[0]), 32'(e0));
        check_eq({tag, "_dp"},   32'(dpo), 32'(edp));
    endtask

    initial begin
        logic       fs;
        logic       fe;
        int         nz;
        int         n;
        int         chg;
        int         bsy;
        logic [3:0] en0;
        logic [6:0] seg0;
        logic [6:0] hold_exp [4];

        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        ena      = 1'b1;
        apply(8'h0C, 8'h00);

        // Reset state
        tick(3);
        check_eq("rst_seg",    32'(bif.seg), 32'h00);
        check_eq("rst_dp",     32'(bif.dp), 32'd0);
        check_eq("rst_dig_en", 32'(bif.dig_en), 32'h1);
        check_eq("rst_ferr",   32'(bif.frame_err), 32'd0);
        check_eq("rst_busy",   32'(bif.busy), 32'd0);

        // Startup 12:00 AM
        rst_n = 1'b1;
        run_conv("start", fs, fe, nz);
        check_eq("start_ferr", 32'(fe), 32'd0);
        tick(2);
        scan_check("start", 7'h06, 7'h5B, 7'h3F, 7'h3F, 4'b0000);

        // 9:59 PM with leading blank
        apply(8'h89, 8'h3B);
        run_conv("pm", fs, fe, nz);
        tick(2);
        scan_check("pm", 7'h00, 7'h6F, 7'h6D, 7'h6F, 4'b0001);

        // Invalid hours 0
        apply(8'h00, 8'h3B);
        bsy = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bif.busy === 1'b1) bsy++;
        end
        check_eq("inv_busy", 32'(bsy), 32'd0);
        check_eq("inv_ferr", 32'(bif.frame_err), 32'd1);
        scan_check("inv", 7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);

        // Recovery with 5:07
        apply(8'h05, 8'h07);
        run_conv("rec", fs, fe, nz);
        check_eq("rec_ferr_during", 32'(fs), 32'd1);
        check_eq("rec_ferr_after",  32'(fe), 32'd0);
        tick(2);
        scan_check("rec", 7'h00, 7'h6D, 7'h3F, 7'h07, 4'b0000);

        // Input change while busy: 1:05 then 2:06
        apply(8'h01, 8'h05);
        tick(2);
        apply(8'h02, 8'h06);
        wait_busy_rise("bb1");
        count_level(1'b1, n);
        check_eq("bb_first_len", 32'(n), 32'd11);
        count_level(1'b0, n);
        check_eq("bb_gap", 32'(n), 32'd1);
        count_level(1'b1, n);
        check_eq("bb_second_len", 32'(n), 32'd11);
        tick(2);
        scan_check("bb", 7'h00, 7'h5B, 7'h3F, 7'h7D, 4'b0000);

        // Async reset at cycle 5 of the minutes conversion (busy cycle 9)
        apply(8'h83, 8'h2A);
        wait_busy_rise("ar");
        tick(8);
        #1 rst_n = 1'b0;
        #1;
        check_eq("ar_seg",    32'(bif.seg), 32'h00);
        check_eq("ar_dp",     32'(bif.dp), 32'd0);
        check_eq("ar_dig_en", 32'(bif.dig_en), 32'h1);
        check_eq("ar_busy",   32'(bif.busy), 32'd0);
        check_eq("ar_ferr",   32'(bif.frame_err), 32'd0);
        tick(2);
        rst_n = 1'b1;
        run_conv("ar_re", fs, fe, nz);
        check_eq("ar_blank_while_busy", 32'(nz), 32'd0);
        tick(2);
        scan_check("ar", 7'h00, 7'h4F, 7'h66, 7'h5B, 4'b0001);

        // Enable low for 100 cycles with a new input pending
        hold_exp[0] = 7'h5B;
        hold_exp[1] = 7'h66;
        hold_exp[2] = 7'h4F;
        hold_exp[3] = 7'h00;
        ena = 1'b0;
        apply(8'h0B, 8'h1E);
        tick(1);
        en0  = bif.dig_en;
        seg0 = bif.seg;
        case (en0)
            4'b0001: check_eq("hold_seg_model", 32'(seg0), 32'(hold_exp[0]));
            4'b0010: check_eq("hold_seg_model", 32'(seg0), 32'(hold_exp[1]));
            4'b0100: check_eq("hold_seg_model", 32'(seg0), 32'(hold_exp[2]));
            4'b1000: check_eq("hold_seg_model", 32'(seg0), 32'(hold_exp[3]));
            default: check_eq("hold_dig_en_onehot", 32'(en0), 32'h1);
        endcase
        chg = 0;
        bsy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((bif.dig_en !== en0) || (bif.seg !== seg0)) chg++;
            if (bif.dp !== ((en0 == 4'b0001) ? 1'b1 : 1'b0)) chg++;
            if (bif.busy === 1'b1) bsy++;
        end
        check_eq("hold_changes", 32'(chg), 32'd0);
        check_eq("hold_busy",    32'(bsy), 32'd0);
        ena = 1'b1;
        run_conv("ena", fs, fe, nz);
        tick(2);
        scan_check("ena", 7'h06, 7'h06, 7'h4F, 7'h3F, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clock_bus_display_scan.md
Name: clock_bus_display_scan

Overview:
- Receive-side consumer of the packed 12-hour time bus produced by the timekeeping core: low byte {am_pm, 0, sec_hi[1:0], hours[3:0]}, high byte {00, minutes[5:0]}.
- Checks each new frame, converts hours and minutes to BCD with a sequential double-dabble engine, and drives a time-multiplexed 4-digit 7-segment display with PM and seconds indicators.
- Sits between the clock core outputs and the board display pins.

Parameters:
- SCAN_DIV, 1024, clk cycles each digit stays enabled; must be ≥2.
- BLANK_LEADING, 1, 1 = blank the hours-tens digit when it is 0.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  global enable; all state holds when low
- time_lo  input  8  {am_pm, rsvd(0), sec_hi[1:0], hours[3:0]}
- time_hi  input  8  {rsvd(00), minutes[5:0]}
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high, seg[0]=a
- dp  output  1  decimal point of the enabled digit, active-high
- dig_en  output  4  one-hot digit enable, active-high
- frame_err  output  1  last evaluated frame was invalid
- busy  output  1  conversion in progress

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. Reset affects every flop immediately, including mid-conversion (the conversion is aborted).
- Reset values: seg=0, dp=0, dig_en=4'b0001, frame_err=0, busy=0, scan index=0, prescaler=0, FSM=IDLE, disp_valid=0. All digits are blank until the first conversion.
- ena low: capture, FSM, prescaler and outputs all hold their values.
- Capture: time_lo and time_hi are registered every cycle while ena=1, giving cap. All logic uses cap, so there is one cycle of input latency.
- Frame validity: hours in 1..12, minutes in 0..59, time_lo[6]=0, time_hi[7:6]=0.
- FSM IDLE: when disp_valid=0 or cap≠src (src is the snapshot taken at the last start), load src=cap.
  - Invalid frame: frame_err←1, the digit registers are set to dash (0x40) on all four digits, disp_valid←1, stay in IDLE.
  - Valid frame: go to CONV_H, busy←1.
- CONV_H: 4 cycles of double-dabble on hours into 8-bit BCD (add 3 to any nibble ≥5 before each shift).
- CONV_M: 6 cycles on minutes, same algorithm.
- LOAD: 1 cycle. Latch hours-tens, hours-ones, minutes-tens, minutes-ones, am_pm and sec_hi[0] into the display registers. Set frame_err←0, disp_valid←1, busy←0 on exit, then go to IDLE.
- Conversion timing: busy is high for exactly 11 cycles. Display registers are updated on the last of those cycles.
- Inputs changing while busy are ignored. Back in IDLE the comparison against src picks up the latest value, so only the final value is guaranteed to be displayed.
- Scan prescaler: counts 0..SCAN_DIV-1 while ena=1. On wrap, the index increments 0→1→2→3→0.
- Digit mapping: 0 = minutes ones, 1 = minutes tens, 2 = hours ones, 3 = hours tens.
- Outputs are registered and update one cycle after an index change or a display-register change.
- Segment codes: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, dash=40, blank=00.
- Hours-tens digit: 0 with BLANK_LEADING=1 gives blank. Dashes are always shown in the error state.
- dp: on digit 0 it shows am_pm (1 = PM). On digit 2 it shows sec_hi[0]. Elsewhere it is 0, and it is 0 in the error state.

Test Plan:
- Startup: reset, then time_lo=0x0C, time_hi=0x00, SCAN_DIV=4 → busy high 11 cycles. Scan then shows d3=06, d2=5B, d1=3F, d0=3F, dp=0 everywhere, frame_err=0.
- PM with leading blank: time_lo=0x89, time_hi=0x3B → d3=00, d2=6F, d1=6D, d0=6F with dp=1 on d0 only.
- Invalid frame: time_lo=0x00 (hours 0) → frame_err=1, busy stays 0, all digits 0x40, dp=0. Then time_lo=0x05, time_hi=0x07 → frame_err clears at LOAD; d2=6D, d1=3F, d0=07.
- Change while busy: apply 01/05, then 2 cycles later 02/06 → two back-to-back conversions (busy low for one IDLE cycle between). Final display d3=00, d2=5B, d1=3F, d0=7D.
- Async reset at cycle 5 of CONV_M → outputs take reset values immediately without a clock edge, and the display stays blank until a new frame is converted.
- ena=0 for 100 cycles with the input changed → dig_en, seg, dp and busy are unchanged. After ena returns to 1, the new value is converted.
